// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial/parallel shift-register family.
// Holds the bit-order enum, the output-holding-register state enum and the
// bit-counter width helper. Build macro: SHIFT_REG_DESER_PARITY_EN.
package shift_reg_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

  // The counter must reach size-1 (data only) or size (data + parity bit).
  function automatic int cnt_width(input int sz);
`ifdef SHIFT_REG_DESER_PARITY_EN
    return $clog2(sz + 2);
`else
    return $clog2(sz + 1);
`endif
  endfunction

endpackage

// File: rtl/shift_reg_out_hold.sv
// Valid/ready output holding register for the deserializer: holds the word,
// its parity flag and the sticky overrun flag.
// Latency: a completed word is visible the cycle after word_vld.
// Backpressure: a word arriving while FULL and not accepted is dropped and sets overrun.
// Ports: word_vld/word_dat/word_par in from the shifter; dout/dout_valid/dout_ready
// consumer handshake; parity_err held with dout; overrun/overrun_clr sticky flag.
module shift_reg_out_hold
  import shift_reg_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            word_vld,
  input  logic [size-1:0] word_dat,
  input  logic            word_par,
  input  logic            dout_ready,
  input  logic            overrun_clr,
  output logic [size-1:0] dout,
  output logic            dout_valid,
  output logic            parity_err,
  output logic            overrun
);

  hold_state_e     state_q, state_d;
  logic [size-1:0] dout_q, dout_d;
  logic            par_q, par_d;
  logic            ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      dout_q  <= '0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      par_q   <= par_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    par_d   = par_q;
    ovr_d   = ovr_q;
    case (state_q)
      EMPTY: begin
        if (word_vld) begin
          dout_d  = word_dat;
          par_d   = word_par;
          state_d = FULL;
        end
      end
      FULL: begin
        if (dout_ready) begin
          // Accept and refill in the same cycle keeps the output continuously valid.
          if (word_vld) begin
            dout_d = word_dat;
            par_d  = word_par;
          end else begin
            state_d = EMPTY;
          end
        end else if (word_vld) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Clear wins over a set in the same cycle.
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);
  assign parity_err = par_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/shift_reg_deser.sv
// Serial-to-parallel deserializer with per-bit valid, selectable bit order,
// word counter, valid/ready output and sticky overrun.
// Latency: word visible the cycle after its last bit is sampled.
// Backpressure: none toward the source; words completing into a held, unaccepted
// output are dropped and flagged via overrun.
// Ports: clk/reset (sync, active-high); din/din_valid serial in; dout/dout_valid/
// dout_ready word out; busy/bit_count progress; overrun/overrun_clr; parity_err.
// Build macro: SHIFT_REG_DESER_PARITY_EN adds a trailing even-parity bit per frame.
module shift_reg_deser
  import shift_reg_pkg::*;
#(
  parameter int size      = 8,
  parameter int msb_first = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din,
  input  logic                       din_valid,
  output logic [size-1:0]            dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic [cnt_width(size)-1:0] bit_count,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic                       parity_err
);

  localparam int         CW    = cnt_width(size);
  localparam bit_order_e ORDER = (msb_first != 0) ? MSB_FIRST : LSB_FIRST;
`ifdef SHIFT_REG_DESER_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(size);
`else
  localparam logic [CW-1:0] LAST = CW'(size - 1);
`endif

  logic [size-1:0] sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] shifted;
  logic            word_vld;
  logic [size-1:0] word_dat;
  logic            word_par;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    if (ORDER == MSB_FIRST) begin
      shifted = {sreg_q[size-2:0], din};
    end else begin
      shifted = {din, sreg_q[size-1:1]};
    end
  end

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    word_vld = 1'b0;
    word_dat = shifted;
    word_par = 1'b0;
    if (din_valid) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        word_vld = 1'b1;
`ifdef SHIFT_REG_DESER_PARITY_EN
        // Last bit is the parity bit: it checks the word but is not shifted in.
        word_dat = sreg_q;
        word_par = (^sreg_q) ^ din;
`else
        sreg_d   = shifted;
`endif
      end else begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  shift_reg_out_hold #(
    .size(size)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .word_vld   (word_vld),
    .word_dat   (word_dat),
    .word_par   (word_par),
    .dout_ready (dout_ready),
    .overrun_clr(overrun_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  assign bit_count = cnt_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_shift_reg_deser.sv
module tb_shift_reg_deser;
  import shift_reg_pkg::*;

  localparam int SZ = 8;
  localparam int CW = cnt_width(SZ);
`ifdef SHIFT_REG_DESER_PARITY_EN
  localparam int FRAME = SZ + 1;
`else
  localparam int FRAME = SZ;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          dout_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [SZ-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic          overrun;
  logic          parity_err;

  logic [SZ-1:0] m_dout;
  logic          m_dout_valid;
  logic          m_busy;
  logic [CW-1:0] m_bit_count;
  logic          m_overrun;
  logic          m_parity_err;

  int tests = 0;
  int failed = 0;
  logic [SZ-1:0] sb[$];

  always #5 clk = ~clk;

  shift_reg_deser #(.size(SZ), .msb_first(0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .bit_count(bit_count), .overrun(overrun),
    .overrun_clr(overrun_clr), .parity_err(parity_err)
  );

  shift_reg_deser #(.size(SZ), .msb_first(1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(m_dout), .dout_valid(m_dout_valid), .dout_ready(dout_ready),
    .busy(m_busy), .bit_count(m_bit_count), .overrun(m_overrun),
    .overrun_clr(overrun_clr), .parity_err(m_parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the scoreboard pops at the falling edge when a handshake will
  // complete on the next rising edge; outputs are checked 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    if (dout_valid && dout_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
      else chk("sb_word", 32'(dout), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // Sends one frame bit0 first; parity frames append even parity (optionally flipped).
  task automatic send_word(input logic [SZ-1:0] w, input bit gap, input bit par_flip);
    logic [SZ:0] bits;
    bits = {(^w) ^ par_flip, w};
    for (int i = 0; i < FRAME; i++) begin
      din = bits[i];
      din_valid = 1'b1;
      tick();
      chk("bit_count_step", 32'(bit_count), 32'((i + 1) % FRAME));
      if (gap && i < FRAME - 1) begin
        din_valid = 1'b0;
        tick();
        chk("bit_count_hold", 32'(bit_count), 32'(i + 1));
      end
    end
    din_valid = 1'b0;
  endtask

  initial begin
    logic [SZ:0] bits;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bit_count", 32'(bit_count), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);

    // LSB-first word, consumer always ready; MSB-first instance sees the same bits
    dout_ready = 1'b1;
    sb.push_back(8'hDD);
    send_word(8'hDD, 1'b0, 1'b0);
    chk("lsb_valid", 32'(dout_valid), 32'h1);
    chk("lsb_dout", 32'(dout), 32'hDD);
    chk("lsb_busy_end", 32'(busy), 32'h0);
    chk("msb_dout", 32'(m_dout), 32'hBB);
    chk("msb_valid", 32'(m_dout_valid), 32'h1);
    tick();
    chk("accept_valid_drop", 32'(dout_valid), 32'h0);

    // Same stream with idle cycles between bits
    sb.push_back(8'hDD);
    send_word(8'hDD, 1'b1, 1'b0);
    chk("gap_dout", 32'(dout), 32'hDD);
    chk("gap_valid", 32'(dout_valid), 32'h1);
    tick();

    // Overrun: consumer stalled while a second word completes
    dout_ready = 1'b0;
    sb.push_back(8'hDD);
    send_word(8'hDD, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b0);
    chk("ovr_dout_kept", 32'(dout), 32'hDD);
    chk("ovr_valid", 32'(dout_valid), 32'h1);
    chk("ovr_set", 32'(overrun), 32'h1);
    tick();
    chk("ovr_sticky", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'h0);
    chk("ovr_valid_after_clr", 32'(dout_valid), 32'h1);
    dout_ready = 1'b1;
    tick();
    chk("ovr_accept_drop", 32'(dout_valid), 32'h0);

    // Back-to-back: accept of DD coincides with completion of 22
    dout_ready = 1'b0;
    sb.push_back(8'hDD);
    sb.push_back(8'h22);
    send_word(8'hDD, 1'b0, 1'b0);
    bits = {^8'h22, 8'h22};
    for (int i = 0; i < FRAME; i++) begin
      din = bits[i];
      din_valid = 1'b1;
      if (i == FRAME - 1) dout_ready = 1'b1;
      tick();
      chk("b2b_valid_held", 32'(dout_valid), 32'h1);
    end
    din_valid = 1'b0;
    chk("b2b_dout", 32'(dout), 32'h22);
    chk("b2b_no_overrun", 32'(overrun), 32'h0);
    tick();
    chk("b2b_valid_drop", 32'(dout_valid), 32'h0);

    // Reset in the middle of a word discards it
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      din_valid = 1'b1;
      tick();
    end
    chk("mid_bit_count", 32'(bit_count), 32'h3);
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_dout_prev", 32'(dout), 32'h22);
    din_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_bit_count", 32'(bit_count), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_dout", 32'(dout), 32'h0);
    chk("mrst_valid", 32'(dout_valid), 32'h0);

`ifdef SHIFT_REG_DESER_PARITY_EN
    // Parity frames: correct parity, then flipped parity
    dout_ready = 1'b1;
    sb.push_back(8'hDD);
    send_word(8'hDD, 1'b0, 1'b0);
    chk("par_ok_dout", 32'(dout), 32'hDD);
    chk("par_ok_err", 32'(parity_err), 32'h0);
    tick();
    sb.push_back(8'hDD);
    send_word(8'hDD, 1'b0, 1'b1);
    chk("par_bad_dout", 32'(dout), 32'hDD);
    chk("par_bad_err", 32'(parity_err), 32'h1);
    tick();
`else
    chk("par_tied_low", 32'(parity_err), 32'h0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
